ulpb_tx_scheduler: RTL and testbench
====================================

Name: ulpb_tx_scheduler

Overview:
Shares one bus node's local transmit interface (REQ_TX/ACK_TX/ADDR_IN/DATA_IN) among NUM_REQ local requesters using round-robin arbitration.
Holds the node request until the node wins bus arbitration, then watches the node's ACK_RECEIVED for the transfer result.
Retries un-acknowledged transfers up to MAX_RETRY times and reports per-requester completion and status over a 4-phase handshake.
Sits between on-chip clients (register file, DMA, sensor FSMs) and the bus node.

Parameters:
NUM_REQ, 4, number of local requesters (>=2)
ADDR_WIDTH, 8, bus address width; must match node
DATA_WIDTH, 32, bus payload width; must match node
TIMEOUT, 64, CLK cycles to wait for ACK_RECEIVED after node releases ACK_TX (>=2)
MAX_RETRY, 2, extra attempts after a timed-out transfer (0 = no retry)

Ports:
CLK  in  1  clock
RESET  in  1  reset; asynchronous, active-low
REQ_VALID  in  NUM_REQ  per-requester transfer request (level)
REQ_ADDR  in  NUM_REQ*ADDR_WIDTH  packed destination addresses; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
REQ_DATA  in  NUM_REQ*DATA_WIDTH  packed payloads; same packing
REQ_DONE  out  NUM_REQ  per-requester completion (level)
REQ_STATUS  out  NUM_REQ  1 = acknowledged by receiver, 0 = failed after retries; valid while REQ_DONE[i]=1
NODE_REQ_TX  out  1  to node REQ_TX
NODE_ADDR_IN  out  ADDR_WIDTH  to node ADDR_IN
NODE_DATA_IN  out  DATA_WIDTH  to node DATA_IN
NODE_ACK_TX  in  1  from node ACK_TX
NODE_ACK_RECEIVED  in  1  from node ACK_RECEIVED
BUSY  out  1  high whenever state != IDLE
GRANT_IDX  out  log2(NUM_REQ)  index of current/last granted requester

Behaviour:
- All outputs are registered. Reset values: NODE_REQ_TX=0, NODE_ADDR_IN=0, NODE_DATA_IN=0, REQ_DONE=0, REQ_STATUS=0, BUSY=0, GRANT_IDX=0. Internally: rr pointer=0, retry_cnt=0, timer=0, ack_seen=0.
- Reset mid-transfer returns to IDLE immediately. No DONE is issued for the aborted transfer.
- States: IDLE, REQ, RELEASE, WAIT_RESULT, COMPLETE.
- IDLE:
  - If any REQ_VALID bit is set, select the first set bit at or after the rr pointer, wrapping modulo NUM_REQ.
  - Latch that requester's address/data into NODE_ADDR_IN/NODE_DATA_IN and set GRANT_IDX. Set rr pointer = GRANT_IDX+1 (wrapping). Clear retry_cnt. Go to REQ.
  - NODE_REQ_TX rises one cycle after the IDLE decision.
  - NODE_ADDR_IN/NODE_DATA_IN stay constant from the latch until the next grant.
- REQ:
  - Hold NODE_REQ_TX=1 until NODE_ACK_TX=1. This may take several bus idle periods if the node loses arbitration.
  - When NODE_ACK_TX=1: drive NODE_REQ_TX=0 next cycle, clear ack_seen, go to RELEASE.
- RELEASE:
  - Wait for NODE_ACK_TX=0, then load timer=TIMEOUT-1 and go to WAIT_RESULT.
- ack_seen:
  - In RELEASE and WAIT_RESULT, any cycle with NODE_ACK_RECEIVED=1 sets ack_seen.
  - NODE_ACK_RECEIVED may be a short pulse, so it is captured stickily.
- WAIT_RESULT:
  - If ack_seen or NODE_ACK_RECEIVED: REQ_STATUS[g]=1, go to COMPLETE.
  - Else if timer==0:
    - If retry_cnt<MAX_RETRY: retry_cnt+1, NODE_REQ_TX=1, go to REQ. Address/data are not re-latched.
    - Else: REQ_STATUS[g]=0, go to COMPLETE.
  - Else: timer decrements.
  - An ack arriving in the same cycle as timer==0 wins: status=1, no retry.
- COMPLETE:
  - REQ_DONE[g]=1 (set on entry).
  - When REQ_VALID[g]=0: clear REQ_DONE[g] next cycle and go to IDLE.
  - REQ_STATUS[g] holds its value until the next grant of g.
- Requester rules:
  - Hold REQ_VALID and the address/data slice until REQ_DONE.
  - Dropping REQ_VALID before DONE does not abort the transfer. DONE is then raised for one cycle only.
  - Non-granted requesters' VALID/DONE are unaffected.
- Fairness: a requester that just completed is lowest priority at the next IDLE decision. Any waiting requester is granted within NUM_REQ-1 transfers.
- Minimum latency, VALID rise to REQ_DONE rise with immediate node ack: 1 (IDLE) + 1 (REQ_TX) + node latency + result wait.
- Timer width ceil(log2(TIMEOUT)); retry_cnt width ceil(log2(MAX_RETRY+1)), minimum 1 bit.

Test Plan:
1. Reset with REQ_VALID=4'b1111 asserted → all outputs 0. After release, GRANT_IDX sequence is 0,1,2,3,0 across five transfers.
2. REQ_VALID[2]=1, addr 8'hAB, data 32'hDEADBEEF → NODE_ADDR_IN=8'hAB, NODE_DATA_IN=32'hDEADBEEF, NODE_REQ_TX=1. ACK_TX model responds 3 cycles later → REQ_TX=0 next cycle. Single-cycle ACK_RECEIVED pulse 20 cycles later → REQ_DONE[2]=1, REQ_STATUS[2]=1.
3. No ACK_RECEIVED, TIMEOUT=64, MAX_RETRY=2 → exactly 3 NODE_REQ_TX assertions, then REQ_DONE=1, REQ_STATUS=0.
4. Node delays ACK_TX 200 cycles (lost arbitration) → NODE_REQ_TX held high continuously; no timeout counted and no retry increment.
5. ACK_RECEIVED coincides with the cycle timer==0 → REQ_STATUS=1, no further REQ_TX.
6. Assert RESET during WAIT_RESULT → next cycle BUSY=0, REQ_DONE=0. Request still valid after release → re-granted with retry_cnt=0.

Source files
------------

// File: rtl/ulpb_tx_scheduler_if.sv
// Bundle between the local requesters, the transmit scheduler and the bus node's transmit port.
// The slave modport is the scheduler's view; master is the requester/node side.
interface ulpb_tx_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            REQ_VALID;
  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR;
  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]            REQ_DONE;
  logic [NUM_REQ-1:0]            REQ_STATUS;
  logic                          NODE_REQ_TX;
  logic [ADDR_WIDTH-1:0]         NODE_ADDR_IN;
  logic [DATA_WIDTH-1:0]         NODE_DATA_IN;
  logic                          NODE_ACK_TX;
  logic                          NODE_ACK_RECEIVED;
  logic                          BUSY;
  logic [GW-1:0]                 GRANT_IDX;

  modport slave (
    input  REQ_VALID, REQ_ADDR, REQ_DATA, NODE_ACK_TX, NODE_ACK_RECEIVED,
    output REQ_DONE, REQ_STATUS, NODE_REQ_TX, NODE_ADDR_IN, NODE_DATA_IN, BUSY, GRANT_IDX
  );

  modport master (
    output REQ_VALID, REQ_ADDR, REQ_DATA, NODE_ACK_TX, NODE_ACK_RECEIVED,
    input  REQ_DONE, REQ_STATUS, NODE_REQ_TX, NODE_ADDR_IN, NODE_DATA_IN, BUSY, GRANT_IDX
  );
endinterface

// File: rtl/ulpb_tx_scheduler.sv
// Round-robin sharing of one bus node's transmit port among NUM_REQ local requesters,
// with ack capture, timeout-driven retry and per-requester done/status handshake.
//
// state         | meaning
// S_IDLE        | pick next requester round-robin, latch its address/data
// S_REQ         | NODE_REQ_TX held high until the node wins arbitration (ACK_TX)
// S_RELEASE     | wait for the node to drop ACK_TX
// S_WAIT_RESULT | count down TIMEOUT cycles for ACK_RECEIVED
// S_COMPLETE    | REQ_DONE[g] high until the requester drops REQ_VALID[g]
module ulpb_tx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64,
  parameter int MAX_RETRY  = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  ulpb_tx_scheduler_if.slave   bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_RELEASE, S_WAIT_RESULT, S_COMPLETE
  } state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         rr_q, rr_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  ack_seen_q, ack_seen_d;
  logic                  req_tx_q, req_tx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [NUM_REQ-1:0]    status_q, status_d;
  logic                  busy_q, busy_d;

  logic                  found;
  logic [GW-1:0]         sel;
  int                    idx;

  // First pending requester at or after the rr pointer, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!found && bus.REQ_VALID[idx]) begin
        found = 1'b1;
        sel   = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    retry_d    = retry_q;
    timer_d    = timer_q;
    ack_seen_d = ack_seen_q;
    req_tx_d   = req_tx_q;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = done_q;
    status_d   = status_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d       = sel;
          addr_d        = bus.REQ_ADDR[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
          data_d        = bus.REQ_DATA[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
          rr_d          = (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
          status_d[sel] = 1'b0;
          retry_d       = '0;
          req_tx_d      = 1'b1;
          state_d       = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.NODE_ACK_TX) begin
          req_tx_d   = 1'b0;
          ack_seen_d = 1'b0;
          state_d    = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (bus.NODE_ACK_RECEIVED) ack_seen_d = 1'b1;
        if (!bus.NODE_ACK_TX) begin
          timer_d = TW'(TIMEOUT - 1);
          state_d = S_WAIT_RESULT;
        end
      end
      S_WAIT_RESULT: begin
        // An ack in the expiry cycle still counts as success.
        if (ack_seen_q || bus.NODE_ACK_RECEIVED) begin
          ack_seen_d        = 1'b1;
          status_d[grant_q] = 1'b1;
          done_d[grant_q]   = 1'b1;
          state_d           = S_COMPLETE;
        end else if (timer_q == '0) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d  = retry_q + 1'b1;
            req_tx_d = 1'b1;
            state_d  = S_REQ;
          end else begin
            status_d[grant_q] = 1'b0;
            done_d[grant_q]   = 1'b1;
            state_d           = S_COMPLETE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_COMPLETE: begin
        if (!bus.REQ_VALID[grant_q]) begin
          done_d[grant_q] = 1'b0;
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      rr_q       <= '0;
      retry_q    <= '0;
      timer_q    <= '0;
      ack_seen_q <= 1'b0;
      req_tx_q   <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= '0;
      status_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      ack_seen_q <= ack_seen_d;
      req_tx_q   <= req_tx_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      status_q   <= status_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.NODE_REQ_TX  = req_tx_q;
  assign bus.NODE_ADDR_IN = addr_q;
  assign bus.NODE_DATA_IN = data_q;
  assign bus.REQ_DONE     = done_q;
  assign bus.REQ_STATUS   = status_q;
  assign bus.BUSY         = busy_q;
  assign bus.GRANT_IDX    = grant_q;
endmodule

// File: tb/tb_ulpb_tx_scheduler.sv
// Scoreboard bench for ulpb_tx_scheduler: directed transfers with a behavioural bus node,
// a requester handshake driver and a monitor that checks each completion.
module tb_ulpb_tx_scheduler;
  localparam int NUM_REQ   = 4;
  localparam int AW        = 8;
  localparam int DW        = 32;
  localparam int TIMEOUT   = 64;
  localparam int MAX_RETRY = 2;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  ulpb_tx_scheduler_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ulpb_tx_scheduler #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  typedef struct {
    int            idx;
    logic          status;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            ntx;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   req_cnt [NUM_REQ];
  int   ack_dly = 1;
  int   rx_dly  = 2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_xfer(input int idx, input logic status, input int ntx);
    exp_t e;
    e.idx    = idx;
    e.status = status;
    e.addr   = bus.REQ_ADDR[idx*AW +: AW];
    e.data   = bus.REQ_DATA[idx*DW +: DW];
    e.ntx    = ntx;
    sb.push_back(e);
  endtask

  task automatic wait_sb(input int budget, input string name);
    int c = 0;
    while (sb.size() != 0 && c < budget) begin
      @(negedge CLK);
      c++;
    end
    @(negedge CLK);
    check(name, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic wait_tx(input logic lvl, input int budget, input string name);
    int c = 0;
    while (bus.NODE_REQ_TX !== lvl && c < budget) begin
      @(negedge CLK);
      c++;
    end
    n_tests++;
    if (bus.NODE_REQ_TX !== lvl) begin
      n_fail++;
      $display("FAIL %s: NODE_REQ_TX=%b after %0d cycles, wanted %b", name, bus.NODE_REQ_TX, c, lvl);
    end
  endtask

  // Behavioural bus node: grants after ack_dly cycles, optional ACK_RECEIVED pulse.
  initial begin
    bus.NODE_ACK_TX       = 1'b0;
    bus.NODE_ACK_RECEIVED = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (RESET && bus.NODE_REQ_TX) begin
        repeat (ack_dly) @(posedge CLK);
        #1 bus.NODE_ACK_TX = 1'b1;
        @(posedge CLK); #1 bus.NODE_ACK_TX = 1'b0;
        if (rx_dly >= 0) begin
          repeat (rx_dly) @(posedge CLK);
          #1 bus.NODE_ACK_RECEIVED = 1'b1;
          @(posedge CLK); #1 bus.NODE_ACK_RECEIVED = 1'b0;
        end
      end
    end
  end

  // Requester side: raise VALID for each queued request, drop it once DONE is seen.
  initial begin
    int issued [NUM_REQ];
    for (int i = 0; i < NUM_REQ; i++) issued[i] = 0;
    bus.REQ_VALID = '0;
    forever begin
      @(negedge CLK);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.REQ_VALID[i] && bus.REQ_DONE[i]) begin
          bus.REQ_VALID[i] = 1'b0;
        end else if (!bus.REQ_VALID[i] && !bus.REQ_DONE[i] && issued[i] < req_cnt[i]) begin
          bus.REQ_VALID[i] = 1'b1;
          issued[i]++;
        end
      end
    end
  end

  // Monitor: each DONE rising edge is matched against the scoreboard head.
  initial begin
    logic [NUM_REQ-1:0] prev_done;
    logic               prev_tx;
    int                 txc;
    exp_t               e;
    prev_done = '0;
    prev_tx   = 1'b0;
    txc       = 0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        prev_done = '0;
        prev_tx   = 1'b0;
        txc       = 0;
      end else begin
        if (bus.NODE_REQ_TX && !prev_tx) txc++;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (bus.REQ_DONE[i] && !prev_done[i]) begin
            if (sb.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_done: requester %0d raised DONE, nothing expected", i);
            end else begin
              e = sb.pop_front();
              check("done_idx",   64'(i),                 64'(e.idx));
              check("grant_idx",  64'(bus.GRANT_IDX),     64'(e.idx));
              check("req_status", 64'(bus.REQ_STATUS[i]), 64'(e.status));
              check("node_addr",  64'(bus.NODE_ADDR_IN),  64'(e.addr));
              check("node_data",  64'(bus.NODE_DATA_IN),  64'(e.data));
              check("req_tx_cnt", 64'(txc),               64'(e.ntx));
            end
            txc = 0;
          end
        end
        prev_done = bus.REQ_DONE;
        prev_tx   = bus.NODE_REQ_TX;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_cnt[i] = 0;
      bus.REQ_ADDR[i*AW +: AW] = AW'(8'h10 + i);
      bus.REQ_DATA[i*DW +: DW] = DW'(32'hC0DE_0000 + i);
    end
    #1 RESET = 1'b0;

    // Test 1: reset with all requesters pending, then round-robin 0,1,2,3,0
    req_cnt[0] = 2; req_cnt[1] = 1; req_cnt[2] = 1; req_cnt[3] = 1;
    repeat (4) @(negedge CLK);
    check("rst_req_tx", 64'(bus.NODE_REQ_TX),  64'd0);
    check("rst_addr",   64'(bus.NODE_ADDR_IN), 64'd0);
    check("rst_data",   64'(bus.NODE_DATA_IN), 64'd0);
    check("rst_done",   64'(bus.REQ_DONE),     64'd0);
    check("rst_status", 64'(bus.REQ_STATUS),   64'd0);
    check("rst_busy",   64'(bus.BUSY),         64'd0);
    check("rst_grant",  64'(bus.GRANT_IDX),    64'd0);
    expect_xfer(0, 1'b1, 1);
    expect_xfer(1, 1'b1, 1);
    expect_xfer(2, 1'b1, 1);
    expect_xfer(3, 1'b1, 1);
    expect_xfer(0, 1'b1, 1);
    RESET = 1'b1;
    wait_sb(2000, "t1_drain");
    repeat (4) @(negedge CLK);
    check("t1_idle_busy", 64'(bus.BUSY), 64'd0);

    // Test 2: single transfer, node grants after 3 cycles, ack pulse 20 cycles later
    bus.REQ_ADDR[2*AW +: AW] = 8'hAB;
    bus.REQ_DATA[2*DW +: DW] = 32'hDEADBEEF;
    ack_dly = 3; rx_dly = 20;
    expect_xfer(2, 1'b1, 1);
    req_cnt[2]++;
    wait_tx(1'b1, 20, "t2_req_tx_rise");
    check("t2_addr",  64'(bus.NODE_ADDR_IN), 64'hAB);
    check("t2_data",  64'(bus.NODE_DATA_IN), 64'hDEADBEEF);
    check("t2_busy",  64'(bus.BUSY),         64'd1);
    check("t2_grant", 64'(bus.GRANT_IDX),    64'd2);
    begin
      int c = 0;
      while (!bus.NODE_ACK_TX && c < 20) begin
        @(negedge CLK);
        c++;
      end
    end
    @(posedge CLK); #1;
    check("t2_req_tx_drop", 64'(bus.NODE_REQ_TX), 64'd0);
    wait_sb(500, "t2_drain");

    // Test 3: no ack at all -> 3 attempts then failure status
    bus.REQ_ADDR[3*AW +: AW] = 8'h33;
    bus.REQ_DATA[3*DW +: DW] = 32'h3333_0003;
    ack_dly = 1; rx_dly = -1;
    expect_xfer(3, 1'b0, 3);
    req_cnt[3]++;
    wait_sb(1000, "t3_drain");

    // Test 4: node loses arbitration for 200 cycles; REQ_TX stays high throughout
    ack_dly = 200; rx_dly = 2;
    expect_xfer(0, 1'b1, 1);
    req_cnt[0]++;
    wait_tx(1'b1, 20, "t4_req_tx_rise");
    lows = 0;
    repeat (195) begin
      @(negedge CLK);
      if (!bus.NODE_REQ_TX) lows++;
    end
    check("t4_req_tx_held", 64'(lows), 64'd0);
    wait_sb(500, "t4_drain");

    // Test 5: ack pulse lands exactly on the timer==0 cycle -> success, no retry
    ack_dly = 1; rx_dly = 64;
    expect_xfer(1, 1'b1, 1);
    req_cnt[1]++;
    wait_sb(500, "t5_drain");
    repeat (4) @(negedge CLK);
    check("t5_no_req_tx", 64'(bus.NODE_REQ_TX), 64'd0);
    check("t5_idle_busy", 64'(bus.BUSY),        64'd0);

    // Test 5b: ack one cycle after expiry is missed -> retries run out, failure
    rx_dly = 65;
    expect_xfer(2, 1'b0, 3);
    req_cnt[2]++;
    wait_sb(1000, "t5b_drain");

    // Test 6: reset during the second attempt's result wait, then full re-grant
    bus.REQ_ADDR[1*AW +: AW] = 8'h61;
    bus.REQ_DATA[1*DW +: DW] = 32'h6666_0001;
    rx_dly = -1;
    req_cnt[1]++;
    wait_tx(1'b1, 20,  "t6_tx1_rise");
    wait_tx(1'b0, 20,  "t6_tx1_fall");
    wait_tx(1'b1, 200, "t6_tx2_rise");
    wait_tx(1'b0, 20,  "t6_tx2_fall");
    repeat (10) @(negedge CLK);
    check("t6_busy_pre", 64'(bus.BUSY), 64'd1);
    RESET = 1'b0;
    @(negedge CLK);
    check("t6_rst_busy",   64'(bus.BUSY),        64'd0);
    check("t6_rst_done",   64'(bus.REQ_DONE),    64'd0);
    check("t6_rst_req_tx", 64'(bus.NODE_REQ_TX), 64'd0);
    expect_xfer(1, 1'b0, 3);
    RESET = 1'b1;
    wait_sb(1000, "t6_drain");

    repeat (5) @(negedge CLK);
    check("final_busy", 64'(bus.BUSY), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
